// File: rtl/lane_capture_pkg.sv
// Shared types for the lane capture stage: lane word and FIFO entry layout.
// The entry carries a timestamp field only when LANE_CAPTURE_TIMESTAMP_EN is defined.
package lane_capture_pkg;

  localparam int LANES = 12;

  typedef logic [LANES-1:0] lane_word_t;

`ifdef LANE_CAPTURE_TIMESTAMP_EN
  // Widest timestamp an entry can hold; the top zero-extends its TS_W-bit counter into it.
  localparam int CAP_TS_W = 32;
`endif

  typedef struct packed {
    lane_word_t lanes;
`ifdef LANE_CAPTURE_TIMESTAMP_EN
    logic [CAP_TS_W-1:0] ts;
`endif
  } cap_entry_t;

endpackage

// File: rtl/lane_capture_fifo_lane_fifo.sv
// First-word-fall-through FIFO of cap_entry_t with a level counter as the
// full/empty discriminator; pointers wrap modulo DEPTH (power of two, >= 2).
module lane_fifo
  import lane_capture_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  cap_entry_t               push_data_i,
  input  logic                     pop_i,
  output cap_entry_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  cap_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/lane_capture_fifo.sv
// Captures every change of the twelve-lane word into a FWFT FIFO drained by valid/ready.
// Optional per-entry cycle timestamp: define LANE_CAPTURE_TIMESTAMP_EN (TS_W <= 32).
module lane_capture_fifo
  import lane_capture_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         lanes_i,
  input  logic                     sample_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_lanes,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  lane_word_t  prev_q, prev_d;
  logic        overflow_q, overflow_d;
  logic        cap_evt, pop, push, drop;
  logic        full, empty;
  cap_entry_t  push_entry, head;

  // Handshake: the head is transferred on any cycle with out_valid && out_ready;
  // out_ready while out_valid is low is ignored, and the head holds until transferred.
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // prev follows every capture event, stored or dropped, so a dropped word never re-triggers.
  assign cap_evt = sample_en && (lanes_i != prev_q);
  assign push    = cap_evt && (!full || pop);
  assign drop    = cap_evt && full && !pop;

  always_comb begin
    prev_d     = cap_evt ? lanes_i : prev_q;
    overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef LANE_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  always_comb begin
    push_entry       = '0;
    push_entry.lanes = lanes_i;
    push_entry.ts    = CAP_TS_W'(ts_q);
  end

  assign out_ts = out_valid ? head.ts[TS_W-1:0] : '0;

  if (TS_W < CAP_TS_W) begin : g_ts_hi
    logic unused_ts_hi;
    assign unused_ts_hi = ^head.ts[CAP_TS_W-1:TS_W];
  end
`else
  always_comb begin
    push_entry       = '0;
    push_entry.lanes = lanes_i;
  end

  assign out_ts = '0;
`endif

  lane_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level)
  );

  // Storage contents are undefined while empty, so the head is masked to zero.
  assign out_lanes = out_valid ? head.lanes : '0;
  assign overflow  = overflow_q;

endmodule
